// File: rtl/montgomery_mul_ds_pkg.sv
// montgomery_pkg: shared FSM states and sizing helpers for the digit-serial Montgomery multiplier.
package montgomery_pkg;

    typedef enum logic [1:0] {IDLE, ITER, SUB, ERR} state_t;

    function automatic int ceil_div(input int x, input int d);
        return (x + d - 1) / d;
    endfunction

    // Wide enough to hold k = NBITS/PBITS itself, so the counter never wraps early.
    function automatic int cnt_width(input int nbits, input int pbits);
        return $clog2(nbits / pbits) + 1;
    endfunction

endpackage

// File: rtl/montgomery_mul_ds_pe.sv
// montgomery_pe: one combinational CIOS digit step, T' = (T + a_i*b + q*m) >> PBITS.
module montgomery_pe #(
    parameter int NBITS = 256,
    parameter int PBITS = 8
) (
    input  logic [NBITS:0]   t_in,
    input  logic [PBITS-1:0] a_i,
    input  logic [NBITS-1:0] b,
    input  logic [NBITS-1:0] m,
    input  logic [PBITS-1:0] m_prime,
    output logic [NBITS:0]   t_out
);
    localparam int W = NBITS + PBITS + 2;

    logic [W-1:0]     t;
    logic [W-1:0]     s;
    logic [PBITS-1:0] q;

    assign t     = W'(t_in) + W'(a_i) * W'(b);
    assign q     = PBITS'(t[PBITS-1:0] * m_prime);
    assign s     = t + W'(q) * W'(m);
    assign t_out = (NBITS + 1)'(s >> PBITS);

endmodule

// File: rtl/montgomery_mul_ds.sv
// montgomery_mul_ds: digit-serial radix-2^PBITS Montgomery multiplier with run-time modulus size.
module montgomery_mul_ds
    import montgomery_pkg::*;
#(
    parameter int NBITS = 256,
    parameter int PBITS = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       enable_p,
    input  logic [NBITS-1:0]           a,
    input  logic [NBITS-1:0]           b,
    input  logic [NBITS-1:0]           m,
    input  logic [$clog2(NBITS)+2:0]   m_size,
    input  logic [PBITS-1:0]           m_prime,
    output logic [NBITS-1:0]           y,
    output logic                       done_irq_p,
    output logic                       busy,
    output logic                       err
);
    localparam int CNT_W = cnt_width(NBITS, PBITS);
    localparam int MS_W  = $clog2(NBITS) + 3;

    state_t             state, state_n;
    logic [NBITS-1:0]   a_sh, b_r, m_r;
    logic [PBITS-1:0]   mp_r;
    logic [CNT_W-1:0]   cnt, k_r, cnt_inc;
    logic [NBITS:0]     t, t_nxt, diff;
    logic               cfg_bad;

    montgomery_pe #(.NBITS(NBITS), .PBITS(PBITS)) u_pe (
        .t_in    (t),
        .a_i     (a_sh[PBITS-1:0]),
        .b       (b_r),
        .m       (m_r),
        .m_prime (mp_r),
        .t_out   (t_nxt)
    );

    assign cnt_inc = cnt + CNT_W'(1);
    assign diff    = t - {1'b0, m_r};
    assign cfg_bad = !m[0] || m_size == '0 || m_size > MS_W'(NBITS);

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = enable_p ? (cfg_bad ? ERR : ITER) : IDLE;
            ITER:    state_n = (cnt_inc == k_r) ? SUB : ITER;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            y          <= '0;
            done_irq_p <= 1'b0;
            busy       <= 1'b0;
            err        <= 1'b0;
            t          <= '0;
            cnt        <= '0;
            a_sh       <= '0;
            b_r        <= '0;
            m_r        <= '0;
            mp_r       <= '0;
            k_r        <= '0;
        end else begin
            state      <= state_n;
            done_irq_p <= 1'b0;
            case (state)
                IDLE: if (enable_p) begin
                    a_sh <= a;
                    b_r  <= b;
                    m_r  <= m;
                    mp_r <= m_prime;
                    k_r  <= CNT_W'(ceil_div(int'(m_size), PBITS));
                    t    <= '0;
                    cnt  <= '0;
                    err  <= 1'b0;
                    busy <= 1'b1;
                end
                ITER: begin
                    t    <= t_nxt;
                    cnt  <= cnt_inc;
                    a_sh <= a_sh >> PBITS;
                end
                SUB: begin
                    y          <= (t >= {1'b0, m_r}) ? NBITS'(diff) : NBITS'(t);
                    done_irq_p <= 1'b1;
                    busy       <= 1'b0;
                end
                default: begin
                    y          <= '0;
                    err        <= 1'b1;
                    done_irq_p <= 1'b1;
                    busy       <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_montgomery_mul_ds.sv
// tb_montgomery_mul_ds: directed checks of the digit-serial Montgomery multiplier at NBITS=16, PBITS=4.
module tb_montgomery_mul_ds;
    logic        clk = 0;
    logic        rst_n = 0;
    logic        enable_p = 0;
    logic [15:0] a = 0, b = 0, m = 0;
    logic [6:0]  m_size = 0;
    logic [3:0]  m_prime = 0;
    logic [15:0] y;
    logic        done_irq_p, busy, err;
    int          pass = 0, total = 0;

    montgomery_mul_ds #(.NBITS(16), .PBITS(4)) dut (
        .clk(clk), .rst_n(rst_n), .enable_p(enable_p), .a(a), .b(b), .m(m),
        .m_size(m_size), .m_prime(m_prime), .y(y), .done_irq_p(done_irq_p),
        .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    task automatic start(input logic [15:0] ta, tb, tm, input logic [6:0] ts, input logic [3:0] tp);
        a = ta; b = tb; m = tm; m_size = ts; m_prime = tp; enable_p = 1;
        @(posedge clk); #1;
        enable_p = 0;
    endtask

    task automatic wait_done(output int lat);
        lat = -1;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk); #1;
            if (done_irq_p) begin lat = n; break; end
        end
    endtask

    task automatic test_reset();
        rst_n = 0;
        repeat (2) @(posedge clk);
        #1;
        total++; if ({y, done_irq_p, busy, err} !== 19'd0) $display("FAIL reset got y=%0d d=%b b=%b e=%b want 0", y, done_irq_p, busy, err); else pass++;
        rst_n = 1;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        int lat;
        start(7, 5, 13, 4, 11);
        total++; if ({busy, done_irq_p} !== 2'b10) $display("FAIL t1_busy got b=%b d=%b want b=1 d=0", busy, done_irq_p); else pass++;
        wait_done(lat);
        total++; if (lat !== 2) $display("FAIL t1_lat got %0d want 2", lat); else pass++;
        total++; if (y !== 16'd3) $display("FAIL t1_y got %0d want 3", y); else pass++;
        total++; if ({busy, err} !== 2'b00) $display("FAIL t1_flags got b=%b e=%b want 0 0", busy, err); else pass++;
        @(posedge clk); #1;
        total++; if (done_irq_p !== 1'b0) $display("FAIL t1_pulse got %b want 0", done_irq_p); else pass++;
    endtask

    task automatic test_errors();
        int lat;
        logic [15:0] em [3] = '{16'd12, 16'd13, 16'd13};
        logic [6:0]  es [3] = '{7'd4, 7'd17, 7'd0};
        for (int i = 0; i < 3; i++) begin
            start(3, 2, em[i], es[i], 11);
            wait_done(lat);
            total++; if (lat !== 1) $display("FAIL err%0d_lat got %0d want 1", i, lat); else pass++;
            total++; if ({err, busy, y} !== {2'b10, 16'd0}) $display("FAIL err%0d_out got e=%b b=%b y=%0d want e=1 b=0 y=0", i, err, busy, y); else pass++;
            @(posedge clk); #1;
            total++; if ({done_irq_p, err} !== 2'b01) $display("FAIL err%0d_hold got d=%b e=%b want d=0 e=1", i, done_irq_p, err); else pass++;
        end
    endtask

    task automatic test_full_width();
        int lat;
        start(16'hFFFE, 16'hFFFC, 16'hFFFF, 16, 1);
        total++; if (err !== 1'b0) $display("FAIL t2_err_clr got %b want 0", err); else pass++;
        wait_done(lat);
        total++; if (lat !== 5) $display("FAIL t2_lat got %0d want 5", lat); else pass++;
        total++; if (y !== 16'd3) $display("FAIL t2_y got %0d want 3", y); else pass++;
    endtask

    task automatic test_msize();
        int lat;
        start(1, 1, 17, 5, 15);
        wait_done(lat);
        total++; if (lat !== 3) $display("FAIL t3a_lat got %0d want 3", lat); else pass++;
        total++; if (y !== 16'd1) $display("FAIL t3a_y got %0d want 1", y); else pass++;
        start(1, 1, 17, 16, 15);
        wait_done(lat);
        total++; if (lat !== 5) $display("FAIL t3b_lat got %0d want 5", lat); else pass++;
        total++; if (y !== 16'd1) $display("FAIL t3b_y got %0d want 1", y); else pass++;
    endtask

    task automatic test_back_to_back();
        int lat;
        start(16'hFFFE, 16'hFFFC, 16'hFFFF, 16, 1);
        @(posedge clk); #1;
        a = 1; b = 1; m = 17; m_size = 5; m_prime = 15; enable_p = 1;
        @(posedge clk); #1;
        enable_p = 0;
        wait_done(lat);
        total++; if (lat !== 3) $display("FAIL t5_lat got %0d want 3", lat); else pass++;
        total++; if (y !== 16'd3) $display("FAIL t5_y got %0d want 3", y); else pass++;
        start(7, 5, 13, 4, 11);
        total++; if ({busy, done_irq_p} !== 2'b10) $display("FAIL t5_accept got b=%b d=%b want b=1 d=0", busy, done_irq_p); else pass++;
        wait_done(lat);
        total++; if (lat !== 2) $display("FAIL t5_b2b_lat got %0d want 2", lat); else pass++;
        total++; if (y !== 16'd3) $display("FAIL t5_b2b_y got %0d want 3", y); else pass++;
    endtask

    task automatic test_abort();
        int lat, pulses;
        start(16'hFFFE, 16'hFFFC, 16'hFFFF, 16, 1);
        repeat (2) begin @(posedge clk); #1; end
        rst_n = 0;
        @(posedge clk); #1;
        total++; if ({busy, y, done_irq_p} !== 18'd0) $display("FAIL t6_abort got b=%b y=%0d d=%b want 0", busy, y, done_irq_p); else pass++;
        rst_n = 1;
        pulses = 0;
        repeat (6) begin @(posedge clk); #1; if (done_irq_p) pulses++; end
        total++; if (pulses !== 0) $display("FAIL t6_no_done got %0d pulses want 0", pulses); else pass++;
        start(7, 5, 13, 4, 11);
        wait_done(lat);
        total++; if (lat !== 2 || y !== 16'd3) $display("FAIL t6_after got lat=%0d y=%0d want lat=2 y=3", lat, y); else pass++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_errors();
        test_full_width();
        test_msize();
        test_back_to_back();
        test_abort();
        $display("%0d/%0d checks passed", pass, total);
        $finish;
    end
endmodule

// File: doc/montgomery_mul_ds.md
Name: montgomery_mul_ds

Overview:
Digit-serial, radix-2^PBITS Montgomery multiplier using CIOS. Modulus size is selected at run time, and the caller supplies the precomputed digit inverse. Computes y = a*b*2^(-PBITS*k) mod m, where k = ceil(m_size/PBITS). Drop-in successor to the bit-serial montgomery_mul cores. Adds busy/err status, operand latching, and invalid-configuration detection.

Parameters:
NBITS, 256, maximum modulus/operand width; must be a multiple of PBITS.
PBITS, 8, digit width (radix 2^PBITS); 1 <= PBITS <= NBITS.

Ports:
clk  in  1  clock, rising edge.
rst_n  in  1  reset, synchronous, active-low.
enable_p  in  1  start pulse; sampled only in IDLE.
a  in  NBITS  operand A; requirement a < m.
b  in  NBITS  operand B; requirement b < m.
m  in  NBITS  modulus; must be odd.
m_size  in  $clog2(NBITS)+3  modulus bit length, 1..NBITS.
m_prime  in  PBITS  value of -m^-1 mod 2^PBITS.
y  out  NBITS  result; held until the next completion.
done_irq_p  out  1  one-cycle completion pulse.
busy  out  1  high while an operation is in flight.
err  out  1  config-error flag for the last operation; valid with done_irq_p, held until the next accept.

Behaviour:
- Reset (rst_n=0 at a clk edge): state=IDLE; y=0; done_irq_p=0; busy=0; err=0; accumulator T=0; digit counter=0.
- rst_n low mid-operation aborts the operation at that edge. No done_irq_p is issued.
- States: IDLE, ITER, SUB, ERR.
- IDLE, enable_p=1 at an edge (E0):
  - Latch a, b, m, m_prime, and k = ceil(m_size/PBITS).
  - Clear T and the counter. Set err=0 and busy=1.
  - Next state is ITER, or ERR if m[0]==0, m_size==0, or m_size>NBITS.
- ITER, one digit per cycle, digit i = counter (LSD first):
  - t = T + a_i*b.
  - q = (t[PBITS-1:0]*m_prime) mod 2^PBITS.
  - T <= (t + q*m) >> PBITS.
  - counter++. After k iterations, go to SUB.
- Width rule: T < 2m always, so T needs NBITS+1 bits. Intermediate t + q*m needs NBITS+PBITS+2 bits. Upper digits of a beyond k are ignored.
- SUB (edge E(k+1)):
  - y <= (T >= m) ? T-m : T.
  - done_irq_p <= 1, busy <= 0, next state IDLE.
- ERR (edge E1): y <= 0, err <= 1, done_irq_p <= 1, busy <= 0, next state IDLE.
- Latency:
  - Valid config: done_irq_p high in the cycle after edge E(k+1), i.e. k+1 cycles after the accepting edge.
  - Error: 1 cycle after the accepting edge.
- done_irq_p is registered and lasts exactly one cycle. y is stable from the done_irq_p cycle until the next completion.
- enable_p while busy=1 is ignored; there is no queuing. Input changes after E0 have no effect.
- Back-to-back: enable_p is accepted in IDLE on the same edge at which done_irq_p falls. Minimum issue interval is k+2 cycles.
- m_size == NBITS gives k = NBITS/PBITS. The counter must not wrap before k.
- No range check on a and b. If a or b >= m, the result is undefined but must still complete in k+1 cycles.

Decomposition:
- Package montgomery_pkg holds:
  - state enum (IDLE/ITER/SUB/ERR);
  - localparam-style function ceil_div(m_size, PBITS);
  - CNT_W = $clog2(NBITS/PBITS)+1.
- One sub-module, montgomery_pe: a combinational digit step with inputs T, a_i, b, m, m_prime and output next T. It is parametrised by NBITS and PBITS and is reused by future multi-digit-per-cycle variants.

Test Plan:
1. NBITS=16, PBITS=4: m=13, m_size=4, m_prime=11, a=7, b=5, enable_p pulse -> done_irq_p 2 cycles later, y=3, err=0, busy high for those 2 cycles.
2. NBITS=16, PBITS=4: m=65535, m_size=16, m_prime=1, a=65534, b=65532 -> done_irq_p 5 cycles after accept, y=3.
3. NBITS=16, PBITS=4: m=17, m_size=5 (k=2), m_prime=15, a=1, b=1 -> y=1 after 3 cycles. Then repeat with m_size=16: a=1, b=1 gives y = 2^-16 mod 17 = 1, after 5 cycles.
4. Error cases:
   - m=12, m_size=4 -> done_irq_p 1 cycle after accept, err=1, y=0.
   - m_size=17 with m=13 -> same response.
   - m_size=0 -> same response.
5. Start test 2, pulse enable_p again at cycle 2 with different operands -> ignored; single done_irq_p with y=3. Then issue test 1 on the done cycle edge -> accepted, y=3 two cycles later.
6. Start test 2, drive rst_n=0 at cycle 3 -> next cycle busy=0, y=0; no done_irq_p. After release, test 1 passes.
